// File: rtl/uart_ascii_pkg.sv
// Shared constants and types for the UART ASCII decimal sequencer.
package uart_ascii_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'd48;
    localparam logic [7:0] ASCII_NINE = 8'd57;
    localparam logic [7:0] ASCII_CR   = 8'd13;
    localparam logic [7:0] ASCII_LF   = 8'd10;

    // Decimal weights indexed by digit position (0 = units).
    localparam logic [15:0] POW10 [0:4] = '{16'd1, 16'd10, 16'd100, 16'd1000, 16'd10000};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SUB     = 3'd1,
        EMIT    = 3'd2,
        SEND_CR = 3'd3,
        SEND_LF = 3'd4,
        DONE    = 3'd5
    } tx_state_t;

endpackage

// File: rtl/uart_ascii_rx_acc.sv
// Rx half: accumulates ASCII decimal digits and publishes the value on CR/LF.
module uart_ascii_rx_acc
    import uart_ascii_pkg::*;
#(
    parameter int Nbits      = 8,
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [Nbits-1:0]  rx_data,
    output logic [DATA_W-1:0] rx_value,
    output logic              rx_value_valid,
    output logic              rx_error
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [DATA_W-1:0] acc_r, acc_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              err_r, err_s;
    logic [DATA_W-1:0] value_r, value_s;
    logic              valid_r, valid_s;
    logic              error_r, error_s;

    logic [Nbits-1:0]  diff_s;
    logic [DATA_W+3:0] wide_acc_s;
    logic [DATA_W+3:0] prod_s;
    logic              is_digit_s;
    logic              is_term_s;

    // Decode the incoming character and compute the widened acc*10+digit.
    always_comb begin
        diff_s     = rx_data - ASCII_ZERO;
        is_digit_s = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
        is_term_s  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
        wide_acc_s = {4'd0, acc_r};
        prod_s     = (wide_acc_s << 3) + (wide_acc_s << 1) + {{DATA_W{1'b0}}, diff_s[3:0]};
    end

    // Next-state for accumulator, digit count, line error flag and pulses.
    always_comb begin
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        value_s = value_r;
        valid_s = 1'b0;
        error_s = 1'b0;
        if (rx_valid) begin
            if (is_digit_s) begin
                if (!err_r) begin
                    if ((cnt_r >= CNT_W'(MAX_DIGITS)) || (prod_s > {4'd0, {DATA_W{1'b1}}})) begin
                        err_s   = 1'b1;
                        error_s = 1'b1;
                    end else begin
                        acc_s = prod_s[DATA_W-1:0];
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    err_s = 1'b1;
                end
            end else if (is_term_s) begin
                if ((cnt_r != CNT_W'(0)) && !err_r) begin
                    value_s = acc_r;
                    valid_s = 1'b1;
                end else begin
                    value_s = value_r;
                end
                acc_s = {DATA_W{1'b0}};
                cnt_s = CNT_W'(0);
                err_s = 1'b0;
            end else begin
                // A bad character poisons the rest of the line; report it once.
                error_s = !err_r;
                err_s   = 1'b1;
            end
        end else begin
            valid_s = 1'b0;
        end
    end

    // Rx state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r   <= {DATA_W{1'b0}};
            cnt_r   <= CNT_W'(0);
            err_r   <= 1'b0;
            value_r <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            value_r <= value_s;
            valid_r <= valid_s;
            error_r <= error_s;
        end
    end

    assign rx_value       = value_r;
    assign rx_value_valid = valid_r;
    assign rx_error       = error_r;

endmodule

// File: rtl/uart_ascii_seq.sv
// UART <-> binary sequencer: Rx digit accumulator plus Tx decimal printer.
module uart_ascii_seq
    import uart_ascii_pkg::*;
#(
    parameter int Nbits      = 8,
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [Nbits-1:0]  rx_data,
    output logic [DATA_W-1:0] rx_value,
    output logic              rx_value_valid,
    output logic              rx_error,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_value,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [Nbits-1:0]  tx_char,
    output logic              tx_char_valid,
    input  logic              tx_char_ready
);

    uart_ascii_rx_acc #(
        .Nbits      (Nbits),
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_rx (
        .clk            (clk),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_value       (rx_value),
        .rx_value_valid (rx_value_valid),
        .rx_error       (rx_error)
    );

    tx_state_t         state_r, state_s;
    logic [DATA_W-1:0] rem_r, rem_s;
    logic [2:0]        pow_idx_r, pow_idx_s;
    logic [3:0]        digit_r, digit_s;
    logic              started_r, started_s;
    logic [Nbits-1:0]  char_r, char_s;
    logic              char_valid_r, char_valid_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [DATA_W-1:0] pow_s;
    logic              accept_s;

    // Tx FSM next state, datapath and next registered outputs.
    always_comb begin
        state_s   = state_r;
        rem_s     = rem_r;
        pow_idx_s = pow_idx_r;
        digit_s   = digit_r;
        started_s = started_r;
        pow_s     = POW10[pow_idx_r];
        accept_s  = char_valid_r && tx_char_ready;

        case (state_r)
            IDLE: begin
                if (tx_start) begin
                    rem_s     = tx_value;
                    pow_idx_s = 3'(MAX_DIGITS - 1);
                    digit_s   = 4'd0;
                    started_s = 1'b0;
                    state_s   = SUB;
                end else begin
                    state_s = IDLE;
                end
            end
            SUB: begin
                if (rem_r >= pow_s) begin
                    rem_s   = rem_r - pow_s;
                    digit_s = digit_r + 4'd1;
                end else begin
                    state_s = EMIT;
                end
            end
            EMIT: begin
                // A non-emitting EMIT (suppressed leading zero) never raised valid.
                if (char_valid_r && !tx_char_ready) begin
                    state_s = EMIT;
                end else begin
                    if (char_valid_r) begin
                        started_s = 1'b1;
                    end else begin
                        started_s = started_r;
                    end
                    if (pow_idx_r == 3'd0) begin
                        state_s = SEND_CR;
                    end else begin
                        pow_idx_s = pow_idx_r - 3'd1;
                        digit_s   = 4'd0;
                        state_s   = SUB;
                    end
                end
            end
            SEND_CR: begin
                if (accept_s) begin
                    state_s = SEND_LF;
                end else begin
                    state_s = SEND_CR;
                end
            end
            SEND_LF: begin
                if (accept_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SEND_LF;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs are derived from the upcoming state so they can be registered.
        char_s       = char_r;
        char_valid_s = 1'b0;
        busy_s       = (state_s != IDLE) && (state_s != DONE);
        done_s       = (state_s == DONE);
        case (state_s)
            EMIT: begin
                if ((digit_s != 4'd0) || started_s || (pow_idx_s == 3'd0)) begin
                    char_valid_s = 1'b1;
                    char_s       = ASCII_ZERO + {4'd0, digit_s};
                end else begin
                    char_valid_s = 1'b0;
                end
            end
            SEND_CR: begin
                char_valid_s = 1'b1;
                char_s       = ASCII_CR;
            end
            SEND_LF: begin
                char_valid_s = 1'b1;
                char_s       = ASCII_LF;
            end
            default: begin
                char_valid_s = 1'b0;
            end
        endcase
    end

    // Tx state register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            rem_r        <= {DATA_W{1'b0}};
            pow_idx_r    <= 3'd0;
            digit_r      <= 4'd0;
            started_r    <= 1'b0;
            char_r       <= ASCII_ZERO;
            char_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            rem_r        <= rem_s;
            pow_idx_r    <= pow_idx_s;
            digit_r      <= digit_s;
            started_r    <= started_s;
            char_r       <= char_s;
            char_valid_r <= char_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign tx_char       = char_r;
    assign tx_char_valid = char_valid_r;
    assign tx_busy       = busy_r;
    assign tx_done       = done_r;

endmodule

// File: tb/tb_uart_ascii_seq.sv
// Self-checking bench for uart_ascii_seq: Rx vector table plus Tx scoreboard.
module tb_uart_ascii_seq;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] rx_value;
    logic        rx_value_valid;
    logic        rx_error;
    logic        tx_start;
    logic [15:0] tx_value;
    logic        tx_busy;
    logic        tx_done;
    logic [7:0]  tx_char;
    logic        tx_char_valid;
    logic        tx_char_ready;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;

    logic [7:0] sb[$];

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst   = 1'b0;
    logic [7:0] prev_char  = 8'd0;

    typedef struct {
        logic [7:0]  ch;
        logic        exp_valid;
        logic [15:0] exp_value;
        logic        exp_error;
    } rx_vec_t;

    rx_vec_t rx_tab[$];

    uart_ascii_seq dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_value       (rx_value),
        .rx_value_valid (rx_value_valid),
        .rx_error       (rx_error),
        .tx_start       (tx_start),
        .tx_value       (tx_value),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_char        (tx_char),
        .tx_char_valid  (tx_char_valid),
        .tx_char_ready  (tx_char_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Tx monitor: hold-stability of an unaccepted char and scoreboard of accepted chars.
    always @(negedge clk) begin
        if (reset && prev_rst && prev_valid && !prev_ready) begin
            n_checks++;
            if (tx_char_valid !== 1'b1 || tx_char !== prev_char) begin
                n_errors++;
                $display("FAIL tx_hold: valid=%0b char=%0d, expected valid=1 char=%0d",
                         tx_char_valid, tx_char, prev_char);
            end
        end
        if (reset && tx_char_valid && tx_char_ready) begin
            n_checks++;
            acc_cnt++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL tx_char: got unexpected char %0d, expected none", tx_char);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (tx_char !== e) begin
                    n_errors++;
                    $display("FAIL tx_char: got %0d, expected %0d", tx_char, e);
                end
            end
        end
        prev_valid = tx_char_valid;
        prev_ready = tx_char_ready;
        prev_rst   = reset;
        prev_char  = tx_char;
    end

    task automatic add(input logic [7:0] c, input logic v, input logic [15:0] val, input logic e);
        rx_tab.push_back('{c, v, val, e});
    endtask

    task automatic start_tx(input logic [15:0] val);
        @(posedge clk); #2;
        tx_start = 1'b1;
        tx_value = val;
        @(posedge clk); #2;
        tx_start = 1'b0;
        @(negedge clk);
        chk("tx_busy_after_start", 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_done(input string name, input bit toggle, input bit inject);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (toggle) tx_char_ready = ~tx_char_ready;
            if (inject && i == 8) begin
                tx_start = 1'b1;
                tx_value = 16'd1;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge clk);
            if (tx_done) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_busy_at_done"}, 32'(tx_busy), 32'd0);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        tx_char_ready = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'd0;
        tx_start      = 1'b0;
        tx_value      = 16'd0;
        tx_char_ready = 1'b0;

        // Vector table: character, then expected outputs one cycle later.
        add(8'd49, 1'b0, 16'd0,     1'b0);  // 1
        add(8'd50, 1'b0, 16'd0,     1'b0);  // 2
        add(8'd51, 1'b0, 16'd0,     1'b0);  // 3
        add(8'd13, 1'b1, 16'd123,   1'b0);  // CR
        add(8'd10, 1'b0, 16'd123,   1'b0);  // LF: no second pulse
        add(8'd54, 1'b0, 16'd123,   1'b0);  // 6
        add(8'd53, 1'b0, 16'd123,   1'b0);  // 5
        add(8'd53, 1'b0, 16'd123,   1'b0);  // 5
        add(8'd51, 1'b0, 16'd123,   1'b0);  // 3
        add(8'd54, 1'b0, 16'd123,   1'b1);  // 6 -> 65536 overflow
        add(8'd13, 1'b0, 16'd123,   1'b0);
        add(8'd55, 1'b0, 16'd123,   1'b0);  // 7
        add(8'd10, 1'b1, 16'd7,     1'b0);
        add(8'd52, 1'b0, 16'd7,     1'b0);  // 4
        add(8'd120, 1'b0, 16'd7,    1'b1);  // x
        add(8'd57, 1'b0, 16'd7,     1'b0);  // 9 ignored
        add(8'd13, 1'b0, 16'd7,     1'b0);
        add(8'd48, 1'b0, 16'd7,     1'b0);  // 0
        add(8'd13, 1'b1, 16'd0,     1'b0);
        for (int k = 0; k < 5; k++) add(8'd48, 1'b0, 16'd0, 1'b0);
        add(8'd49, 1'b0, 16'd0,     1'b1);  // sixth digit
        add(8'd13, 1'b0, 16'd0,     1'b0);
        add(8'd120, 1'b0, 16'd0,    1'b1);  // x
        add(8'd121, 1'b0, 16'd0,    1'b0);  // y: no second error
        add(8'd10, 1'b0, 16'd0,     1'b0);
        add(8'd54, 1'b0, 16'd0,     1'b0);  // 65535 exactly fits
        add(8'd53, 1'b0, 16'd0,     1'b0);
        add(8'd53, 1'b0, 16'd0,     1'b0);
        add(8'd51, 1'b0, 16'd0,     1'b0);
        add(8'd53, 1'b0, 16'd0,     1'b0);
        add(8'd13, 1'b1, 16'd65535, 1'b0);
        add(8'd57, 1'b0, 16'd65535, 1'b0);  // 9
        add(8'd13, 1'b1, 16'd9,     1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_value", 32'(rx_value), 32'd0);
        chk("rst_rx_value_valid", 32'(rx_value_valid), 32'd0);
        chk("rst_rx_error", 32'(rx_error), 32'd0);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_tx_char_valid", 32'(tx_char_valid), 32'd0);
        chk("rst_tx_char", 32'(tx_char), 32'd48);
        @(posedge clk); #2;
        reset = 1'b1;

        foreach (rx_tab[i]) begin
            @(posedge clk); #2;
            rx_valid = 1'b1;
            rx_data  = rx_tab[i].ch;
            @(posedge clk); #2;
            rx_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("rx_valid[%0d]", i), 32'(rx_value_valid), 32'(rx_tab[i].exp_valid));
            chk($sformatf("rx_value[%0d]", i), 32'(rx_value), 32'(rx_tab[i].exp_value));
            chk($sformatf("rx_error[%0d]", i), 32'(rx_error), 32'(rx_tab[i].exp_error));
        end

        // Value 0 with ready always high: a single "0".
        tx_char_ready = 1'b1;
        sb.push_back(8'd48); sb.push_back(8'd13); sb.push_back(8'd10);
        start_tx(16'd0);
        wait_done("tx0", 1'b0, 1'b0);

        // 65535 with ready toggling, plus an ignored start mid-print.
        sb.push_back(8'd54); sb.push_back(8'd53); sb.push_back(8'd53);
        sb.push_back(8'd51); sb.push_back(8'd53); sb.push_back(8'd13); sb.push_back(8'd10);
        start_tx(16'd65535);
        wait_done("tx65535", 1'b1, 1'b1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("tx_ignored_start_idle", 32'(tx_busy), 32'd0);
        chk("tx_ignored_start_sb", 32'(sb.size()), 32'd0);

        // 1002 aborted by reset after the second character.
        sb.push_back(8'd49); sb.push_back(8'd48); sb.push_back(8'd48);
        sb.push_back(8'd50); sb.push_back(8'd13); sb.push_back(8'd10);
        begin
            int base;
            bit hit;
            base = acc_cnt;
            hit  = 1'b0;
            start_tx(16'd1002);
            for (int i = 0; i < 200; i++) begin
                if (acc_cnt >= base + 2) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("tx1002_two_chars", 32'(hit), 32'd1);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_tx_busy", 32'(tx_busy), 32'd0);
        chk("abort_tx_char_valid", 32'(tx_char_valid), 32'd0);
        chk("abort_tx_char", 32'(tx_char), 32'd48);
        chk("abort_tx_done", 32'(tx_done), 32'd0);
        chk("abort_rx_value", 32'(rx_value), 32'd0);
        sb.delete();
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("abort_no_resume", 32'(tx_char_valid), 32'd0);

        sb.push_back(8'd53); sb.push_back(8'd13); sb.push_back(8'd10);
        start_tx(16'd5);
        wait_done("tx5", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
